sw_tx_mux_rr: RTL and testbench

- Parametrised N-port GMII transmit aggregator. It merges NPORT independent 8-bit GMII transmit streams onto one GMII output.
- Each port has its own buffer. Arbitration is frame-level round-robin, and a programmable minimum inter-frame gap is enforced on the output.
- Sits between the per-port MAC/switch logic and the shared uplink GMII, in the same position as the fixed 4-port tx mux. It adds buffering, fairness, overflow handling and gap control.

---
 rtl/sw_tx_mux_rr.sv | 175 +++++++++++++++++
 tb/tb_sw_tx_mux_rr.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_tx_mux_rr.sv
// N-port GMII transmit aggregator: per-port FIFOs with overflow truncation,
// frame-level round-robin arbitration and a programmable minimum inter-frame gap.
module sw_tx_mux_rr #(
   parameter int NPORT = 4,
   parameter int DEPTH = 64,
   parameter int IFG   = 12
) (
   input  logic                 I_125m_clk,
   input  logic                 I_rst,
   input  logic [NPORT-1:0]     I_tx_gmii_dv,
   input  logic [NPORT-1:0]     I_tx_gmii_err,
   input  logic [8*NPORT-1:0]   I_tx_gmii_d,
   output logic                 O_tx_gmii_dv,
   output logic [7:0]           O_tx_gmii_d,
   output logic                 O_tx_gmii_err,
   output logic [NPORT-1:0]     O_ovf_pulse,
   output logic [NPORT-1:0]     O_grant
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned PTRW = AW + 1;
   localparam int unsigned PW   = (NPORT > 1) ? $clog2(NPORT) : 1;
   localparam int unsigned CW   = (IFG > 0) ? $clog2(IFG + 1) : 1;

   typedef struct packed {
      logic       eof;
      logic       err;
      logic [7:0] d;
   } entry_t;

   typedef enum logic [1:0] {ARB, XFER, GAP} state_t;

   state_t           state;
   logic [PW-1:0]    rr_ptr;
   logic [PW-1:0]    sel_idx;
   logic             sel_valid;
   logic [CW-1:0]    gap_cnt;
   logic [NPORT-1:0] req;
   logic [NPORT-1:0] pop;
   logic [NPORT-1:0] ovf;
   entry_t           rd_data [NPORT];
   entry_t           head;
   logic             head_valid;

   for (genvar k = 0; k < NPORT; k++) begin : g_port
      logic            dv_d;
      logic            err_d;
      logic [7:0]      d_d;
      logic [PTRW-1:0] wr_ptr;
      logic [PTRW-1:0] rd_ptr;
      logic            drop_pend;
      logic            full;
      logic            wr_due;
      logic            term;
      logic            wr_en;
      entry_t          wr_data;
      entry_t          mem [DEPTH];

      assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      assign req[k]  = (wr_ptr != rd_ptr);
      assign pop[k]  = (state == XFER) && O_grant[k] && req[k];
      assign wr_due  = dv_d && !drop_pend;
      assign ovf[k]  = wr_due && full;
      // A truncated frame is closed once its tail has passed and there is room.
      assign term    = drop_pend && !full && (!dv_d || !I_tx_gmii_dv[k]);
      assign wr_en   = (wr_due && !full) || term;
      assign wr_data = term ? entry_t'{eof: 1'b1, err: 1'b1, d: 8'h00}
                            : entry_t'{eof: dv_d && !I_tx_gmii_dv[k], err: err_d, d: d_d};
      assign rd_data[k] = mem[rd_ptr[AW-1:0]];

      always_ff @(posedge I_125m_clk or negedge I_rst) begin
         if (!I_rst) begin
            dv_d      <= 1'b0;
            err_d     <= 1'b0;
            d_d       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            drop_pend <= 1'b0;
         end else begin
            dv_d  <= I_tx_gmii_dv[k];
            err_d <= I_tx_gmii_err[k];
            d_d   <= I_tx_gmii_d[8*k +: 8];
            if (wr_en)
               wr_ptr <= wr_ptr + PTRW'(1);
            if (pop[k])
               rd_ptr <= rd_ptr + PTRW'(1);
            if (ovf[k])
               drop_pend <= 1'b1;
            else if (term)
               drop_pend <= 1'b0;
         end
      end

      always_ff @(posedge I_125m_clk) begin
         if (wr_en)
            mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   assign head       = rd_data[rr_ptr];
   assign head_valid = req[rr_ptr];

   // Round-robin search starting just after the last granted port.
   always_comb begin
      int j;
      sel_valid = 1'b0;
      sel_idx   = '0;
      j         = 0;
      for (int i = 1; i <= NPORT; i++) begin
         j = int'(rr_ptr) + i;
         if (j >= NPORT)
            j = j - NPORT;
         if (!sel_valid && req[PW'(j)]) begin
            sel_valid = 1'b1;
            sel_idx   = PW'(j);
         end
      end
   end

   always_ff @(posedge I_125m_clk or negedge I_rst) begin
      if (!I_rst) begin
         state         <= ARB;
         rr_ptr        <= PW'(NPORT - 1);
         gap_cnt       <= '0;
         O_grant       <= '0;
         O_tx_gmii_dv  <= 1'b0;
         O_tx_gmii_d   <= '0;
         O_tx_gmii_err <= 1'b0;
         O_ovf_pulse   <= '0;
      end else begin
         O_ovf_pulse   <= ovf;
         O_tx_gmii_dv  <= 1'b0;
         O_tx_gmii_d   <= '0;
         O_tx_gmii_err <= 1'b0;
         case (state)
            ARB: begin
               if (sel_valid) begin
                  rr_ptr  <= sel_idx;
                  O_grant <= NPORT'(1) << sel_idx;
                  state   <= XFER;
               end else begin
                  O_grant <= '0;
               end
            end
            XFER: begin
               // An empty FIFO mid-frame (source underrun) leaves dv low and holds.
               if (head_valid) begin
                  O_tx_gmii_dv  <= 1'b1;
                  O_tx_gmii_d   <= head.d;
                  O_tx_gmii_err <= head.err;
                  if (head.eof) begin
                     O_grant <= '0;
                     if (IFG > 0) begin
                        state   <= GAP;
                        gap_cnt <= CW'(IFG);
                     end else begin
                        state <= ARB;
                     end
                  end
               end
            end
            GAP: begin
               gap_cnt <= gap_cnt - CW'(1);
               if (gap_cnt == CW'(1))
                  state <= ARB;
            end
            default: begin
               state   <= ARB;
               O_grant <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sw_tx_mux_rr.sv
// Directed bench for sw_tx_mux_rr: a 64-deep and a 16-deep instance share the inputs;
// each scenario checks its instance's output frames, grants, gaps and overflow pulses.
`timescale 1ns/1ps
module tb_sw_tx_mux_rr;

   localparam int NP = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [NP-1:0]   tx_dv;
   logic [NP-1:0]   tx_err;
   logic [8*NP-1:0] tx_d;

   logic          a_dv, b_dv, a_err, b_err;
   logic [7:0]    a_d, b_d;
   logic [NP-1:0] a_ovf, b_ovf, a_grant, b_grant;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always #4 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sw_tx_mux_rr #(.NPORT(NP), .DEPTH(64), .IFG(12)) u_dut (
      .I_125m_clk(clk), .I_rst(rst_n),
      .I_tx_gmii_dv(tx_dv), .I_tx_gmii_err(tx_err), .I_tx_gmii_d(tx_d),
      .O_tx_gmii_dv(a_dv), .O_tx_gmii_d(a_d), .O_tx_gmii_err(a_err),
      .O_ovf_pulse(a_ovf), .O_grant(a_grant));

   sw_tx_mux_rr #(.NPORT(NP), .DEPTH(16), .IFG(12)) u_dut16 (
      .I_125m_clk(clk), .I_rst(rst_n),
      .I_tx_gmii_dv(tx_dv), .I_tx_gmii_err(tx_err), .I_tx_gmii_d(tx_d),
      .O_tx_gmii_dv(b_dv), .O_tx_gmii_d(b_d), .O_tx_gmii_err(b_err),
      .O_ovf_pulse(b_ovf), .O_grant(b_grant));

   // Output monitors: byte log, frame start (byte index and cycle), gaps, grant log, ovf counts.
   logic [8:0]    a_ob[$], b_ob[$];
   int            a_fb[$], b_fb[$], a_fs[$], b_fs[$], a_gap[$], b_gap[$];
   logic [NP-1:0] a_gl[$], b_gl[$];
   int            a_ovc [NP] = '{0, 0, 0, 0};
   int            b_ovc [NP] = '{0, 0, 0, 0};
   logic          a_pdv = 1'b0, b_pdv = 1'b0;
   logic [NP-1:0] a_pg = '0, b_pg = '0;
   int            a_last = -1, b_last = -1;

   always @(negedge clk) begin
      if (!rst_n) a_last = -1;
      if (a_dv) begin
         if (!a_pdv) begin
            a_fs.push_back(cyc);
            a_fb.push_back(a_ob.size());
            if (a_last >= 0) a_gap.push_back(cyc - a_last - 1);
         end
         a_ob.push_back({a_err, a_d});
         a_last = cyc;
      end
      if (a_grant != '0 && a_pg == '0) a_gl.push_back(a_grant);
      for (int p = 0; p < NP; p++) if (a_ovf[p]) a_ovc[p]++;
      a_pdv = a_dv;
      a_pg  = a_grant;
   end

   always @(negedge clk) begin
      if (!rst_n) b_last = -1;
      if (b_dv) begin
         if (!b_pdv) begin
            b_fs.push_back(cyc);
            b_fb.push_back(b_ob.size());
            if (b_last >= 0) b_gap.push_back(cyc - b_last - 1);
         end
         b_ob.push_back({b_err, b_d});
         b_last = cyc;
      end
      if (b_grant != '0 && b_pg == '0) b_gl.push_back(b_grant);
      for (int p = 0; p < NP; p++) if (b_ovf[p]) b_ovc[p]++;
      b_pdv = b_dv;
      b_pg  = b_grant;
   end

   // Snapshot of monitor positions at the start of a scenario.
   int ma_f, ma_g, ma_gl, mb_f, mb_gl;
   int ma_ov [NP];
   int mb_ov [NP];

   task automatic mark();
      ma_f = a_fb.size(); ma_g = a_gap.size(); ma_gl = a_gl.size();
      mb_f = b_fb.size(); mb_gl = b_gl.size();
      for (int p = 0; p < NP; p++) begin
         ma_ov[p] = a_ovc[p];
         mb_ov[p] = b_ovc[p];
      end
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   // Per-port frame source.
   int         d_len [NP], d_pos [NP], d_dly [NP], d_reps [NP], d_idle [NP], d_err [NP], d_first [NP];
   logic [7:0] d_base [NP];

   task automatic launch(input int p, input int len, input logic [7:0] base, input int eidx,
                         input int dly, input int reps);
      d_len[p] = len; d_base[p] = base; d_err[p] = eidx; d_dly[p] = dly;
      d_reps[p] = reps; d_pos[p] = 0; d_idle[p] = 0; d_first[p] = -1;
   endtask

   task automatic clear_drv();
      for (int p = 0; p < NP; p++) launch(p, 1, 8'h00, -1, 0, 0);
   endtask

   task automatic drive_cycle();
      logic [NP-1:0]   dv, er;
      logic [8*NP-1:0] dd;
      dv = '0; er = '0; dd = '0;
      for (int p = 0; p < NP; p++) begin
         if (d_dly[p] > 0) d_dly[p]--;
         else if (d_reps[p] > 0) begin
            if (d_idle[p] > 0) d_idle[p]--;
            else begin
               if (d_first[p] < 0) d_first[p] = cyc;
               dv[p] = 1'b1;
               er[p] = (d_pos[p] == d_err[p]);
               dd[8*p +: 8] = 8'(int'(d_base[p]) + d_pos[p]);
               d_pos[p]++;
               if (d_pos[p] == d_len[p]) begin
                  d_pos[p] = 0; d_reps[p]--; d_idle[p] = 1;
               end
            end
         end
      end
      tx_dv = dv; tx_err = er; tx_d = dd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      drive_cycle();
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic apply_reset();
      clear_drv();
      rst_n = 1'b0;
      run(3);
      rst_n = 1'b1;
   endtask

   // Compare one output frame (u: 0 = deep instance, 1 = 16-deep) against its expected bytes.
   task automatic chk_frame(input string nm, input int u, input int fi, input int len,
                            input logic [7:0] base, input int eidx, input bit trunc);
      int b0, tot, nf, flen, n, bad, first;
      logic [8:0] got, exp, fgot, fexp;
      nf  = (u == 0) ? a_fb.size() : b_fb.size();
      tot = (u == 0) ? a_ob.size() : b_ob.size();
      if (fi >= nf) begin
         chk({nm, "_present"}, 64'(nf), 64'(fi + 1));
         return;
      end
      b0   = (u == 0) ? a_fb[fi] : b_fb[fi];
      flen = (fi + 1 < nf) ? ((u == 0) ? a_fb[fi+1] : b_fb[fi+1]) - b0 : tot - b0;
      n    = len + (trunc ? 1 : 0);
      chk({nm, "_len"}, 64'(flen), 64'(n));
      bad = 0; first = -1; fgot = '0; fexp = '0;
      for (int i = 0; i < n; i++) begin
         exp = (i < len) ? {(i == eidx), 8'(int'(base) + i)} : 9'h100;
         if (b0 + i >= tot) got = 9'h1FF;
         else got = (u == 0) ? a_ob[b0+i] : b_ob[b0+i];
         if (got !== exp) begin
            if (bad == 0) begin first = i; fgot = got; fexp = exp; end
            bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL %s_data: %0d bad bytes, first at %0d got {err,d}=0x%0h want 0x%0h",
                  nm, bad, first, fgot, fexp);
      end
   endtask

   function automatic logic [63:0] pack_gl(input int u, input int start, input int n);
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < n; i++) begin
         if (u == 0 && start + i < a_gl.size()) v |= 64'(a_gl[start+i]) << (4 * i);
         if (u == 1 && start + i < b_gl.size()) v |= 64'(b_gl[start+i]) << (4 * i);
      end
      return v;
   endfunction

   typedef struct {
      int            port;
      int            len;
      logic [7:0]    base;
      int            eidx;
      logic [NP-1:0] grant;
   } vec_t;

   vec_t vecs [4];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int guard;
      int ov;

      vecs[0] = '{port: 0, len: 64, base: 8'h00, eidx: -1, grant: 4'b0001};
      vecs[1] = '{port: 2, len: 10, base: 8'hA0, eidx: 5,  grant: 4'b0100};
      vecs[2] = '{port: 3, len: 1,  base: 8'h5A, eidx: -1, grant: 4'b1000};
      vecs[3] = '{port: 1, len: 16, base: 8'h10, eidx: 15, grant: 4'b0010};

      tx_dv = '0; tx_err = '0; tx_d = '0;
      clear_drv();
      run(3);
      chk("rst_dv",    64'(a_dv),    64'(0));
      chk("rst_d_err", 64'({a_err, a_d}), 64'(0));
      chk("rst_grant", 64'(a_grant), 64'(0));
      chk("rst_ovf",   64'(a_ovf),   64'(0));
      chk("rst16_out", 64'({b_dv, b_err, b_d, b_grant, b_ovf}), 64'(0));
      rst_n = 1'b1;

      // Single-frame vectors: latency, contiguity, data, err placement, grant.
      for (int v = 0; v < 4; v++) begin
         apply_reset();
         mark();
         launch(vecs[v].port, vecs[v].len, vecs[v].base, vecs[v].eidx, 0, 1);
         run(vecs[v].len + 30);
         chk($sformatf("v%0d_frames", v), 64'(a_fb.size() - ma_f), 64'(1));
         if (a_fs.size() > ma_f)
            chk($sformatf("v%0d_latency", v), 64'(a_fs[ma_f] - d_first[vecs[v].port]), 64'(4));
         chk_frame($sformatf("v%0d", v), 0, ma_f, vecs[v].len, vecs[v].base, vecs[v].eidx, 1'b0);
         chk($sformatf("v%0d_grant", v), pack_gl(0, ma_gl, 1), 64'(vecs[v].grant));
         ov = 0;
         for (int p = 0; p < NP; p++) ov += a_ovc[p] - ma_ov[p];
         chk($sformatf("v%0d_ovf", v), 64'(ov), 64'(0));
      end

      // All four ports start a 20-byte frame together.
      apply_reset();
      mark();
      for (int p = 0; p < NP; p++) launch(p, 20, 8'(p * 32), -1, 0, 1);
      run(200);
      chk("all4_grants", pack_gl(0, ma_gl, 4), 64'h8421);
      chk("all4_ngaps", 64'(a_gap.size() - ma_g), 64'(3));
      for (int i = 0; i < 3; i++)
         if (ma_g + i < a_gap.size()) chk($sformatf("all4_gap%0d", i), 64'(a_gap[ma_g+i]), 64'(13));
      for (int p = 0; p < NP; p++)
         chk_frame($sformatf("all4_f%0d", p), 0, ma_f + p, 20, 8'(p * 32), -1, 1'b0);
      if (a_fs.size() > ma_f) chk("all4_latency", 64'(a_fs[ma_f] - d_first[0]), 64'(4));
      ov = 0;
      for (int p = 0; p < NP; p++) ov += a_ovc[p] - ma_ov[p];
      chk("all4_ovf", 64'(ov), 64'(0));

      // Ports 1 and 3 back-to-back: grants must alternate.
      apply_reset();
      mark();
      launch(1, 16, 8'h10, -1, 0, 4);
      launch(3, 16, 8'h30, -1, 0, 4);
      run(400);
      chk("rr_ngrants", 64'(a_gl.size() - ma_gl), 64'(8));
      chk("rr_grants", pack_gl(0, ma_gl, 8), 64'h8282_8282);
      for (int f = 0; f < 8; f++)
         chk_frame($sformatf("rr_f%0d", f), 0, ma_f + f, 16, (f % 2 == 0) ? 8'h10 : 8'h30, -1, 1'b0);

      // 16-deep instance: port 1 overflows behind a long port 0 frame.
      apply_reset();
      mark();
      launch(0, 200, 8'h00, -1, 0, 1);
      launch(1, 40, 8'h40, -1, 1, 1);
      run(300);
      launch(1, 8, 8'hC0, -1, 0, 1);
      run(60);
      chk("ovf_grants", pack_gl(1, mb_gl, 3), 64'h221);
      chk_frame("ovf_p0", 1, mb_f, 200, 8'h00, -1, 1'b0);
      chk_frame("ovf_p1_trunc", 1, mb_f + 1, 16, 8'h40, -1, 1'b1);
      chk_frame("ovf_p1_next", 1, mb_f + 2, 8, 8'hC0, -1, 1'b0);
      chk("ovf_pulse_p1", 64'(b_ovc[1] - mb_ov[1]), 64'(1));
      chk("ovf_pulse_p0", 64'(b_ovc[0] - mb_ov[0]), 64'(0));

      // Reset asserted in the middle of a frame.
      apply_reset();
      mark();
      launch(0, 20, 8'h80, -1, 0, 1);
      guard = 0;
      while ((a_ob.size() - (ma_f < a_fb.size() ? a_fb[ma_f] : a_ob.size())) < 7 && guard < 40) begin
         step();
         @(negedge clk);
         #1;
         guard++;
      end
      chk("mid_reach", 64'(guard < 40), 64'(1));
      chk("mid_dv_before", 64'(a_dv), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out", 64'({a_dv, a_err, a_d, a_grant, a_ovf}), 64'(0));
      clear_drv();
      run(3);
      rst_n = 1'b1;
      mark();
      launch(0, 8, 8'hE0, -1, 0, 1);
      run(30);
      chk("post_frames", 64'(a_fb.size() - ma_f), 64'(1));
      if (a_fs.size() > ma_f) chk("post_latency", 64'(a_fs[ma_f] - d_first[0]), 64'(4));
      chk_frame("post", 0, ma_f, 8, 8'hE0, -1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
